instruction_fetch: RTL

Front end of the core. Keeps the fetch PC, issues in-order word reads to instruction memory, and buffers returned words in a small FIFO. It presents one instruction at a time, with its PC, to the instruction decoder over a valid/ready handshake. Control-flow redirects (JAL/JALR/taken branch) flush the buffer and any in-flight reads, then restart fetch at the new PC.

---
 rtl/instruction_fetch.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the fetch PC, issues in-order word reads to
// instruction memory and buffers returned words, with their PCs, for the decoder.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,

    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(DEPTH) + 2;
    localparam int SW = DW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          fault_q, fault_d;
    logic [DW-1:0] discard_q, discard_d;

    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [AW-1:0] fifo_rd_q, fifo_rd_d;
    logic [AW-1:0] fifo_wr_q, fifo_wr_d;
    logic [CW-1:0] occ_q, occ_d;

    logic [31:0]   pcq_q [DEPTH];
    logic [AW-1:0] pcq_rd_q, pcq_rd_d;
    logic [AW-1:0] pcq_wr_q, pcq_wr_d;
    logic [CW-1:0] outst_q, outst_d;

    logic [SW-1:0] inflight;
    logic [DW-1:0] pending;
    logic          req_fire;
    logic          resp_drop;
    logic          resp_keep;
    logic          fifo_push;
    logic          fifo_pop;

    // Words still owed to the drop counter also hold a credit, so that
    // discard + outstanding + buffered never exceeds DEPTH.
    assign inflight = SW'(discard_q) + SW'(outst_q) + SW'(occ_q);
    assign pending  = discard_q + DW'(outst_q);

    assign mem_req_valid = !reset && !fault_q && !redirect_valid && (inflight < SW'(DEPTH));
    assign mem_req_addr  = {fetch_pc_q[31:2], 2'b00};
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign resp_drop = mem_resp_valid && (discard_q != '0);
    assign resp_keep = mem_resp_valid && (discard_q == '0);
    assign fifo_push = resp_keep && !redirect_valid;

    assign instr_valid = (occ_q != '0);
    assign fifo_pop    = instr_valid && instr_ready && !redirect_valid;
    assign instruction = instr_valid ? fifo_data_q[fifo_rd_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc_q[fifo_rd_q]   : '0;
    assign fetch_fault = fault_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        discard_d  = discard_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        occ_d      = occ_q;
        pcq_rd_d   = pcq_rd_q;
        pcq_wr_d   = pcq_wr_q;
        outst_d    = outst_q;

        if (redirect_valid) begin
            // Everything in flight becomes a discard; a response landing this
            // same cycle is itself dropped and retires one of them.
            fetch_pc_d = redirect_pc;
            fault_d    = (redirect_pc[1:0] != 2'b00);
            discard_d  = (mem_resp_valid && (pending != '0)) ? pending - DW'(1) : pending;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            occ_d      = '0;
            pcq_rd_d   = '0;
            pcq_wr_d   = '0;
            outst_d    = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pcq_wr_d   = pcq_wr_q + AW'(1);
            end
            if (resp_drop) begin
                discard_d = discard_q - DW'(1);
            end
            if (resp_keep) begin
                pcq_rd_d = pcq_rd_q + AW'(1);
            end
            if (fifo_push) begin
                fifo_wr_d = fifo_wr_q + AW'(1);
            end
            if (fifo_pop) begin
                fifo_rd_d = fifo_rd_q + AW'(1);
            end
            outst_d = outst_q + CW'(req_fire) - CW'(resp_keep);
            occ_d   = occ_q + CW'(fifo_push) - CW'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            discard_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            occ_q      <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
            outst_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
            discard_q  <= discard_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            occ_q      <= occ_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
            outst_q    <= outst_d;
        end
    end

    // Payload storage needs no reset; occupancy and pointers qualify it.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_q[pcq_wr_q] <= fetch_pc_q;
        end
        if (fifo_push) begin
            fifo_data_q[fifo_wr_q] <= mem_resp_data;
            fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
        end
    end

endmodule
